// File: rtl/mant_div_seq.sv
// Sequential restoring mantissa divider: one quotient bit per clock through a WIDTH+1 PE row.
// Build option: define MANT_DIV_EARLY_TERM_EN to finish as soon as the remainder becomes zero.
module mant_div_seq #(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned QW    = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             Ack,
  output logic             Busy,
  output logic             Done,
  output logic [QW-1:0]    Quotient,
  output logic             Sticky,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [QW-1:0]    q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   row;
  logic [WIDTH:0]   shifted;
  logic [QW-1:0]    q_next;
  logic             cout;

  assign b_ext = {1'b0, d_q};

  // PE row: ripple R + ~B + 1; the final carry-out selects difference or pass-through in every cell
  always_comb begin : pe_row
    logic c;
    c    = 1'b1;
    diff = '0;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      diff[i] = r_q[i] ^ ~b_ext[i] ^ c;
      c       = (r_q[i] & ~b_ext[i]) | ((r_q[i] ^ ~b_ext[i]) & c);
    end
    cout = c;
  end

  assign row     = cout ? diff : r_q;
  assign shifted = {row[WIDTH-1:0], 1'b0};
  assign q_next  = {q_q[QW-2:0], cout};

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          sticky_d = 1'b0;
          if (Divisor[WIDTH-1]) begin
            r_d     = {1'b0, Dividend};
            d_d     = Divisor;
            q_d     = '0;
            cnt_d   = CW'(QW);
            dz_d    = 1'b0;
            state_d = CALC;
            busy_d  = 1'b1;
          end else begin
            q_d     = '1;
            dz_d    = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      CALC: begin
        busy_d = 1'b1;
        q_d    = q_next;
        r_d    = shifted;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          sticky_d = |row;
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
`ifdef MANT_DIV_EARLY_TERM_EN
        else if (shifted == '0) begin
          // Exact result: remaining quotient bits are all zero
          q_d      = q_next << (cnt_q - CW'(1));
          sticky_d = 1'b0;
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
`endif
      end
      DONE: begin
        done_d = 1'b1;
        if (Ack) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      d_q      <= d_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Quotient = q_q;
  assign Sticky   = sticky_q;
  assign DivZero  = dz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Directed self-checking bench for mant_div_seq (default WIDTH=24, QW=26).
// Latencies are counted as rising edges from the load edge (inclusive) until Done is seen.
module tb_mant_div_seq;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned QW    = 26;
`ifdef MANT_DIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Ack;
  logic             Busy;
  logic             Done;
  logic [QW-1:0]    Quotient;
  logic             Sticky;
  logic             DivZero;

  int tests = 0;
  int fails = 0;

  mant_div_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Ack      (Ack),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Sticky   (Sticky),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for Done; n counts further falling edges waited
  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Start = 1'b0; Ack = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({Busy, Done, Sticky, DivZero} !== 4'b0000 || Quotient !== 26'h0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b q=%h s=%b dz=%b, want all 0",
               Busy, Done, Quotient, Sticky, DivZero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [WIDTH-1:0] dvd [8];
    logic [WIDTH-1:0] dvs [8];
    logic [QW-1:0]    q   [8];
    logic             s   [8];
    logic             dz  [8];
    int               lf  [8];
    int               le  [8];
    int n, lat, want_lat;
    dvd = '{24'h800000, 24'hC00000, 24'h800000, 24'h800000, 24'hC00000, 24'hFFFFFF, 24'h800000, 24'hAAAAAA};
    dvs = '{24'h800000, 24'h800000, 24'hC00000, 24'h000000, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'hAAAAAA};
    q   = '{26'h2000000, 26'h3000000, 26'h1555555, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFC, 26'h1000001, 26'h2000000};
    s   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dz  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lf  = '{27, 27, 27, 1, 1, 27, 27, 27};
    le  = '{2, 3, 27, 1, 1, 25, 27, 2};
    for (int i = 0; i < 8; i++) begin
      Dividend = dvd[i]; Divisor = dvs[i]; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      tests++;
      if (Busy !== ~dz[i] || Done !== dz[i]) begin
        fails++;
        $display("FAIL vec%0d first_cycle: busy=%b done=%b want busy=%b done=%b",
                 i, Busy, Done, ~dz[i], dz[i]);
      end
      wait_done(n);
      lat = n + 1;
      want_lat = ET ? le[i] : lf[i];
      tests++;
      if (lat !== want_lat) begin
        fails++;
        $display("FAIL vec%0d latency: got %0d want %0d", i, lat, want_lat);
      end
      tests++;
      if (Quotient !== q[i]) begin
        fails++;
        $display("FAIL vec%0d quotient: got %h want %h", i, Quotient, q[i]);
      end
      tests++;
      if (Sticky !== s[i] || DivZero !== dz[i]) begin
        fails++;
        $display("FAIL vec%0d flags: sticky=%b divzero=%b want %b %b",
                 i, Sticky, DivZero, s[i], dz[i]);
      end
      Ack = 1'b1;
      @(negedge clk);
      Ack = 1'b0;
      tests++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL vec%0d ack: done=%b busy=%b want 0 0", i, Done, Busy);
      end
    end
  endtask

  task automatic test_hold_ignore;
    int n;
    Dividend = 24'h800000; Divisor = 24'hC00000; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    // Start, Ack and operand changes mid-CALC must be ignored
    Start = 1'b1; Ack = 1'b1; Dividend = 24'hFFFFFF; Divisor = 24'h800000;
    @(negedge clk);
    Start = 1'b0; Ack = 1'b0;
    wait_done(n);
    tests++;
    if (!Done || Quotient !== 26'h1555555 || Sticky !== 1'b1 || DivZero !== 1'b0) begin
      fails++;
      $display("FAIL calc_ignore: done=%b q=%h s=%b dz=%b want 1 1555555 1 0",
               Done, Quotient, Sticky, DivZero);
    end
    for (int k = 0; k < 10; k++) begin
      Start = (k == 4);
      @(negedge clk);
      tests++;
      if (Done !== 1'b1 || Busy !== 1'b0 || Quotient !== 26'h1555555 || Sticky !== 1'b1) begin
        fails++;
        $display("FAIL hold%0d: done=%b busy=%b q=%h s=%b want 1 0 1555555 1",
                 k, Done, Busy, Quotient, Sticky);
      end
    end
    Start = 1'b1; Ack = 1'b1;
    @(negedge clk);
    Start = 1'b0; Ack = 1'b0;
    @(negedge clk);
    tests++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== 26'h1555555) begin
      fails++;
      $display("FAIL start_ack: done=%b busy=%b q=%h want 0 0 1555555", Done, Busy, Quotient);
    end
  endtask

  task automatic test_reset_mid_calc;
    int n, lat, want_lat;
    Dividend = 24'h800000; Divisor = 24'hC00000; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({Busy, Done, Sticky, DivZero} !== 4'b0000 || Quotient !== 26'h0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h s=%b dz=%b want all 0",
               Busy, Done, Quotient, Sticky, DivZero);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", Busy, Done);
    end
    Dividend = 24'hC00000; Divisor = 24'h800000; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(n);
    lat = n + 1;
    want_lat = ET ? 3 : 27;
    tests++;
    if (lat !== want_lat || Quotient !== 26'h3000000 || Sticky !== 1'b0 || DivZero !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: lat=%0d q=%h s=%b dz=%b want %0d 3000000 0 0",
               lat, Quotient, Sticky, DivZero, want_lat);
    end
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold_ignore();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mant_div_seq.md
# mant_div_seq

Sequential restoring mantissa divider for the floating-point divide path. It owns one row of WIDTH+1 subtract/select PE cells and drives them for one quotient bit per clock. An FSM sequences the row with a Start/Done/Ack handshake. Inputs are normalized mantissas with the hidden bit included. Outputs are a raw quotient plus sticky and divide-by-zero flags for the downstream normalize/round stage.

## Interface
- WIDTH, 24: mantissa width including hidden bit.
- QW, WIDTH+2: quotient width, 1 integer bit plus WIDTH+1 fraction bits (derived; not overridden).
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Dividend  in  WIDTH  numerator mantissa; MSB expected 1.
- Divisor  in  WIDTH  denominator mantissa; MSB 0 treated as zero.
- Ack  in  1  consumer accepts result; sampled only in DONE.
- Busy  out  1  high in CALC.
- Done  out  1  high in DONE; result outputs are stable while high.
- Quotient  out  QW  floor(Dividend/Divisor × 2^(QW-1)).
- Sticky  out  1  final remainder nonzero.
- DivZero  out  1  Divisor MSB was 0.

## Operation
- States: IDLE, CALC, DONE. Reset (rst_n=0 at an edge) forces IDLE. It clears Busy, Done, Quotient, Sticky, DivZero, the remainder register and the bit counter. This holds mid-CALC and mid-DONE; the in-flight operation is dropped.
- IDLE, Start=1, Divisor[WIDTH-1]=1:
  - R (WIDTH+1 bits) = {0, Dividend}; D = Divisor.
  - Quotient cleared; counter = QW; go to CALC.
- IDLE, Start=1, Divisor[WIDTH-1]=0: DivZero=1, Quotient = all ones, Sticky=0; go directly to DONE.
- CALC, each cycle:
  - PE row computes R − {0,D} with A=R, B=D bits, Cin=1 into the LSB cell, ripple carry upward.
  - Final Cout=1 means no borrow (R ≥ D). It drives sel of every cell.
  - Row result is R−D if Cout=1, otherwise R.
  - Quotient shifts left with Cout inserted at the LSB.
  - R ← row result << 1; counter decrements.
  - When counter reaches 1 at the edge, go to DONE. Sticky = |(row result) latched on that same edge.
- DONE: outputs held. Ack=1 at an edge → IDLE and Done drops. Start is ignored in CALC and DONE, including a simultaneous Start+Ack in DONE. Ack is ignored outside DONE.
- Operands are captured at the load edge. Input changes during CALC have no effect.

## Timing
- Load edge t0: state becomes CALC, Busy=1 after t0.
- Iterations run on edges t1..tQW. At tQW the state becomes DONE: Busy=0, Done=1.
- Done is therefore visible QW cycles after the load edge, 26 cycles at default WIDTH.
- Divide-by-zero path: Done=1 after t0.
- Minimum back-to-back: Ack at edge tA returns to IDLE. Start is sampled at tA+1 at the earliest.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- MANT_DIV_EARLY_TERM_EN defined: in CALC, if the shifted remainder produced at an edge is zero, go to DONE on that edge.
  - The remaining quotient bits are zero-filled: Quotient shifted left by the counter's remaining count.
  - Sticky=0.
  - Latency becomes variable, between 1 and QW cycles.
- Not defined: fixed QW-cycle latency always. Results are bit-identical in both builds; only Done timing differs.

## Test plan
- Dividend=0x800000, Divisor=0x800000, Start pulse:
  - Quotient=0x2000000, Sticky=0, DivZero=0.
  - Done 26 cycles after load, or 1 cycle with MANT_DIV_EARLY_TERM_EN.
- Dividend=0xC00000, Divisor=0x800000: Quotient=0x3000000, Sticky=0. Early-term build gives Done 2 cycles after load.
- Dividend=0x800000, Divisor=0xC00000: Quotient=0x1555555, Sticky=1, Done at 26 cycles in both builds.
- Divisor=0x000000:
  - DivZero=1, Quotient=0x3FFFFFF, Done 1 cycle after load.
  - Ack returns to IDLE. Next valid Start computes normally with DivZero=0.
- Hold Ack=0 for 10 cycles in DONE: outputs unchanged. Start pulses during CALC and DONE are ignored. Start+Ack together in DONE → IDLE, no new load.
- rst_n=0 at iteration 12: next cycle state IDLE, all outputs 0. A fresh Start then yields the correct result with full latency.
